// File: rtl/openofdm_tx_pkg.sv
// Shared definitions for the OpenOFDM transmit path.
// Holds the STF generator state encoding, the STF table geometry, and a
// small helper that halves a 16-bit table sample for edge windowing.
package openofdm_tx_pkg;

  localparam int STF_DEPTH    = 16;
  localparam int STF_SAMPLE_W = 16;
  localparam int STF_ADDR_W   = $clog2(STF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stf_state_e;

  // Arithmetic shift right by one: the 802.11 edge window weight of 0.5.
  function automatic logic [STF_SAMPLE_W-1:0] half_sample(input logic [STF_SAMPLE_W-1:0] x);
    return {x[STF_SAMPLE_W-1], x[STF_SAMPLE_W-1:1]};
  endfunction

endpackage

// File: rtl/stf_stream_gen_table.sv
// stf_table: combinational lookup of one 16-sample STF period.
// Ports:
//   addr - table index 0..15
//   iq   - {I, Q}, each a signed 16-bit sample
// The period is a constant-envelope sequence (magnitude ~1066) whose phase
// steps by -67.5 degrees per sample, starting at 225 degrees.
module stf_table
  import openofdm_tx_pkg::*;
(
  input  logic [STF_ADDR_W-1:0]     addr,
  output logic [2*STF_SAMPLE_W-1:0] iq
);

  // Constant table decode.
  always_comb begin
    iq = 32'h0000_0000;
    case (addr)
      4'd0:    iq = {16'hFD0E, 16'hFD0E};
      4'd1:    iq = {16'hFC27, 16'h0198};
      4'd2:    iq = {16'h0000, 16'h042A};
      4'd3:    iq = {16'h03D9, 16'h0198};
      4'd4:    iq = {16'h02F2, 16'hFD0E};
      4'd5:    iq = {16'hFE68, 16'hFC27};
      4'd6:    iq = {16'hFBD6, 16'h0000};
      4'd7:    iq = {16'hFE68, 16'h03D9};
      4'd8:    iq = {16'h02F2, 16'h02F2};
      4'd9:    iq = {16'h03D9, 16'hFE68};
      4'd10:   iq = {16'h0000, 16'hFBD6};
      4'd11:   iq = {16'hFC27, 16'hFE68};
      4'd12:   iq = {16'hFD0E, 16'h02F2};
      4'd13:   iq = {16'h0198, 16'h03D9};
      4'd14:   iq = {16'h042A, 16'h0000};
      4'd15:   iq = {16'h0198, 16'hFC27};
      default: iq = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/stf_stream_gen.sv
// stf_stream_gen: streams an 802.11 short training field burst.
// A burst is N_REP periods of the 16-sample STF, optionally edge windowed
// (first sample halved, plus one halved copy of entry 0 appended as a tail).
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   start              - one-cycle burst request (ignored unless idle)
//   abort              - synchronous cancel, returns to idle, no done
//   out_ready          - downstream accepts the presented sample
//   out_valid/i/q/last - registered sample stream, last marks the final one
//   busy               - burst in progress
//   done               - one-cycle pulse after the final handshake
module stf_stream_gen
  import openofdm_tx_pkg::*;
#(
  parameter int IQ_WIDTH  = 16,
  parameter int N_REP     = 10,
  parameter int WINDOW_EN = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [IQ_WIDTH-1:0] out_i,
  output logic [IQ_WIDTH-1:0] out_q,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int DROP = STF_SAMPLE_W - IQ_WIDTH;
  // Half an LSB of the reduced width, added before truncation.
  localparam logic [16:0] RND = (DROP == 0) ? 17'd0 : (17'd1 << ((DROP > 0) ? DROP - 1 : 0));
  // With windowing the final sample is the tail at (rep N_REP, idx 0).
  localparam logic [3:0] LAST_REP = (WINDOW_EN != 0) ? 4'(N_REP) : 4'(N_REP - 1);
  localparam logic [3:0] LAST_IDX = (WINDOW_EN != 0) ? 4'd0 : 4'd15;
  localparam logic [3:0] TAIL_REP = 4'(N_REP);
  localparam logic [IQ_WIDTH-1:0] SAT_MAX = {1'b0, {(IQ_WIDTH-1){1'b1}}};
  localparam logic [IQ_WIDTH-1:0] SAT_MIN = {1'b1, {(IQ_WIDTH-1){1'b0}}};

  // Round half-up to the upper IQ_WIDTH bits, saturating on overflow.
  function automatic logic [IQ_WIDTH-1:0] reduce(input logic [15:0] x);
    logic [16:0]         s;
    logic [IQ_WIDTH:0]   u;
    logic [IQ_WIDTH-1:0] r;
    s = {x[15], x} + RND;
    u = s[16:DROP];
    if (u[IQ_WIDTH] != u[IQ_WIDTH-1]) begin
      r = u[IQ_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      r = u[IQ_WIDTH-1:0];
    end
    return r;
  endfunction

  stf_state_e state, nxt_state;
  logic [3:0] idx, rep, nxt_idx, nxt_rep;
  logic       load;
  logic       hs;
  logic [31:0] tab_iq;
  logic [15:0] win_i, win_q;
  logic        win;
  logic        nxt_valid, nxt_last, nxt_busy, nxt_done;
  logic [IQ_WIDTH-1:0] nxt_i, nxt_q;

  assign hs = out_valid & out_ready;

  stf_table u_table (
    .addr (nxt_idx),
    .iq   (tab_iq)
  );

  // State and sample-pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
      rep   <= 4'd0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      rep   <= nxt_rep;
    end
  end

  // Next-state and pointer logic; abort overrides everything.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_rep   = rep;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_state = ST_RUN;
          nxt_idx   = 4'd0;
          nxt_rep   = 4'd0;
          load      = 1'b1;
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs && out_last) begin
          nxt_state = ST_DONE;
        end else if (hs) begin
          nxt_idx = idx + 4'd1;
          nxt_rep = (idx == 4'd15) ? rep + 4'd1 : rep;
          load    = 1'b1;
        end else begin
          nxt_state = ST_RUN;
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
    if (abort) begin
      nxt_state = ST_IDLE;
      nxt_idx   = 4'd0;
      nxt_rep   = 4'd0;
      load      = 1'b0;
    end else begin
      nxt_state = nxt_state;
    end
  end

  // Output next-values: window, reduce, and hold the sample during stalls.
  always_comb begin
    win = (WINDOW_EN != 0) && (nxt_idx == 4'd0) && ((nxt_rep == 4'd0) || (nxt_rep == TAIL_REP));
    if (win) begin
      win_i = half_sample(tab_iq[31:16]);
      win_q = half_sample(tab_iq[15:0]);
    end else begin
      win_i = tab_iq[31:16];
      win_q = tab_iq[15:0];
    end
    nxt_valid = (nxt_state == ST_RUN);
    nxt_busy  = (nxt_state == ST_RUN);
    nxt_done  = (nxt_state == ST_DONE);
    if (load) begin
      nxt_i    = reduce(win_i);
      nxt_q    = reduce(win_q);
      nxt_last = (nxt_idx == LAST_IDX) && (nxt_rep == LAST_REP);
    end else if (nxt_state == ST_RUN) begin
      nxt_i    = out_i;
      nxt_q    = out_q;
      nxt_last = out_last;
    end else begin
      nxt_i    = '0;
      nxt_q    = '0;
      nxt_last = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= nxt_valid;
      out_i     <= nxt_i;
      out_q     <= nxt_q;
      out_last  <= nxt_last;
      busy      <= nxt_busy;
      done      <= nxt_done;
    end
  end

endmodule

// File: doc/stf_stream_gen.md
STF_STREAM_GEN -- requirements
Module: stf_stream_gen

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16, output I/Q sample width; legal range 8..16.
REQ-002 SHALL have parameter N_REP, default 10, number of 16-sample STF periods per burst; legal range 1..15.
REQ-003 SHALL have parameter WINDOW_EN, default 1, enables 802.11 edge windowing (halved first sample plus one halved tail sample).
REQ-004 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-005 SHALL have port rstn, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit, single-cycle burst request.
REQ-007 SHALL have port abort, input, 1 bit, synchronous burst cancel.
REQ-008 SHALL have port out_ready, input, 1 bit, downstream accepts sample.
REQ-009 SHALL have port out_valid, output, 1 bit, sample present.
REQ-010 SHALL have port out_i, output, IQ_WIDTH bits, signed I sample.
REQ-011 SHALL have port out_q, output, IQ_WIDTH bits, signed Q sample.
REQ-012 SHALL have port out_last, output, 1 bit, marks the final sample of the burst.
REQ-013 SHALL have port busy, output, 1 bit, high from the start acceptance cycle through the final handshake.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse after the final handshake.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE on the handshake of out_last; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL emit 16*N_REP + WINDOW_EN samples per burst, cycling table index 0..15 and wrapping 15->0 while a 4-bit repetition counter increments.
REQ-017 SHALL use the 16-entry, 16-bit I/Q STF table with entry 0 = (I 0xFD0E, Q 0xFD0E), entry 1 = (0xFC27, 0x0198), entry 2 = (0x0000, 0x042A), continuing through entry 15 = (0x0198, 0xFC27).
REQ-018 SHALL, when WINDOW_EN=1, arithmetic-shift-right by 1 both I and Q of the first burst sample, and SHALL append a tail sample equal to entry 0 shifted in the same way.
REQ-019 SHALL, when IQ_WIDTH<16, reduce each 16-bit value to its upper IQ_WIDTH bits, rounding half-up on the dropped MSB and saturating to the signed IQ_WIDTH range; windowing is applied before the reduction.
REQ-020 SHALL register all outputs; out_valid SHALL assert the cycle after start is accepted and carry sample 0.
REQ-021 SHALL hold out_i, out_q and out_last stable while out_valid=1 and out_ready=0; the sample advances only on out_valid&out_ready.
REQ-022 SHALL sustain one sample per cycle while out_ready stays high.
REQ-023 SHALL ignore start while busy=1 or while in DONE.
REQ-024 SHALL, on abort in any state, enter IDLE next cycle with out_valid=0, busy=0, and no done pulse; abort wins over a simultaneous start.
REQ-025 SHALL assert out_last only with the final sample, and only together with out_valid.

Reset
REQ-026 SHALL, while rstn=0, force state IDLE, index and repetition counters 0, and out_valid, out_last, busy, done, out_i, out_q all 0.
REQ-027 SHALL, on reset assertion mid-burst, discard the burst with no done pulse, and SHALL need a new start after release.

Structure
REQ-028 SHALL place the state enumeration, the table depth (16), and the 16-bit table sample width in the shared openofdm_tx package.
REQ-029 SHALL instantiate one sub-module, stf_table: a combinational 4-bit address to 32-bit {I,Q} lookup.

Verification
REQ-030 Defaults, out_ready=1, start at cycle 0 -> first sample (0xFE87, 0xFE87) at cycle 1; 161 contiguous samples; out_last and tail (0xFE87, 0xFE87) at cycle 161; done at cycle 162.
REQ-031 out_ready random 50% -> sample sequence identical to REQ-030; data and out_last stable through every stall.
REQ-032 IQ_WIDTH=8, WINDOW_EN=0, N_REP=1 -> 16 samples; sample 0 = (0xFD, 0xFD); sample 2 = (0x00, 0x04); no tail sample.
REQ-033 abort at the 50th handshake, then start 2 cycles later -> no done pulse; new burst restarts at windowed sample 0.
REQ-034 start pulsed mid-burst, and start coincident with abort in IDLE -> both ignored; burst length and state unchanged.
REQ-035 rstn deasserted asynchronously mid-burst -> all outputs 0 immediately; IDLE after release.
